// File: rtl/qspi_arb_pkg.sv
// Shared state encoding and bus-idle constants for the QSPI bus arbiter.
package qspi_arb_pkg;

    typedef enum logic [2:0] {
        ST_CORE,
        ST_WAIT_IDLE,
        ST_GUARD_IN,
        ST_PRG,
        ST_GUARD_OUT
    } arb_state_e;

    localparam logic       IDLE_SCK   = 1'b0;
    localparam logic       IDLE_CS_N  = 1'b1;
    localparam logic [3:0] IDLE_SDO   = 4'b0000;
    localparam logic [3:0] IDLE_SDOEN = 4'b0000;

    // Wide enough for the largest programmer timeout (65535).
    localparam int TMR_W = 16;

endpackage

// File: rtl/qspi_arb_timer.sv
// Loadable down-counter; done_o is high while the count is zero.
module qspi_arb_timer
    import qspi_arb_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/qspi_bus_arbiter.sv
// Hands the QSPI pins between the core and an external programmer with idle guard bands.
// Optional programmer-inactivity reclaim: define QSPI_ARB_PRG_TIMEOUT_EN.
module qspi_bus_arbiter
    import qspi_arb_pkg::*;
#(
    parameter int GUARD_CYCLES = 4,
    parameter int PRG_TIMEOUT  = 1024
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       core_sck_i,
    input  logic       core_cs_rom_ni,
    input  logic       core_cs_ram_ni,
    input  logic [3:0] core_sdo_i,
    input  logic [3:0] core_sdoen_i,
    output logic [3:0] core_sdi_o,
    output logic       core_hold_o,
    input  logic       prg_req_i,
    output logic       prg_gnt_o,
    input  logic       prg_sck_i,
    input  logic       prg_cs_ni,
    input  logic       prg_copi_i,
    output logic       prg_cipo_o,
    output logic       qspi_sck_o,
    output logic       qspi_cs_rom_no,
    output logic       qspi_cs_ram_no,
    output logic [3:0] qspi_sdo_o,
    output logic [3:0] qspi_sdoen_o,
    input  logic [3:0] qspi_sdi_i,
    output logic       conflict_o
);

    // Loading N-1 and leaving on zero gives exactly N cycles in the state.
    localparam logic [TMR_W-1:0] GUARD_LOAD = TMR_W'(GUARD_CYCLES - 1);
    localparam logic [TMR_W-1:0] TO_LOAD    = TMR_W'(PRG_TIMEOUT - 1);

    arb_state_e        state_q, state_d;
    logic              conflict_q, conflict_d;
    logic              tmr_load, tmr_dec, tmr_done;
    logic [TMR_W-1:0]  tmr_val;
    logic              core_idle;
    logic              gate_req;

    assign core_idle = core_cs_rom_ni && core_cs_ram_ni;

`ifdef QSPI_ARB_PRG_TIMEOUT_EN
    logic rearm_q, rearm_d;
    logic timeout_hit;

    // After a reclaim the programmer must drop and re-raise its request.
    assign gate_req = prg_req_i && !rearm_q;

    always_comb begin
        rearm_d = rearm_q;
        if (!prg_req_i)       rearm_d = 1'b0;
        else if (timeout_hit) rearm_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) rearm_q <= 1'b0;
        else       rearm_q <= rearm_d;
    end
`else
    assign gate_req = prg_req_i;
`endif

    qspi_arb_timer #(.W(TMR_W)) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .done_o     (tmr_done)
    );

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = GUARD_LOAD;
`ifdef QSPI_ARB_PRG_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state_q)
            ST_CORE: begin
                if (gate_req) state_d = ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (!prg_req_i) begin
                    state_d = ST_CORE;
                end else if (core_idle) begin
                    state_d  = ST_GUARD_IN;
                    tmr_load = 1'b1;
                end
            end
            ST_GUARD_IN: begin
                if (tmr_done) begin
                    state_d = ST_PRG;
`ifdef QSPI_ARB_PRG_TIMEOUT_EN
                    tmr_load = 1'b1;
                    tmr_val  = TO_LOAD;
`endif
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_PRG: begin
                if (!prg_req_i && prg_cs_ni) begin
                    state_d  = ST_GUARD_OUT;
                    tmr_load = 1'b1;
                end
`ifdef QSPI_ARB_PRG_TIMEOUT_EN
                else if (!prg_cs_ni || prg_sck_i) begin
                    tmr_load = 1'b1;
                    tmr_val  = TO_LOAD;
                end else if (tmr_done) begin
                    state_d     = ST_GUARD_OUT;
                    tmr_load    = 1'b1;
                    timeout_hit = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
`endif
            end
            ST_GUARD_OUT: begin
                if (tmr_done) state_d = ST_CORE;
                else          tmr_dec = 1'b1;
            end
            default: state_d = ST_CORE;
        endcase
    end

    always_comb begin
        conflict_d = conflict_q;
        if ((state_q == ST_GUARD_IN || state_q == ST_PRG || state_q == ST_GUARD_OUT)
            && !core_idle)
            conflict_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_CORE;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            conflict_q <= conflict_d;
        end
    end

    // Pin mux straight off the registered state; reset overrides everything.
    always_comb begin
        qspi_sck_o     = IDLE_SCK;
        qspi_cs_rom_no = IDLE_CS_N;
        qspi_cs_ram_no = IDLE_CS_N;
        qspi_sdo_o     = IDLE_SDO;
        qspi_sdoen_o   = IDLE_SDOEN;
        core_sdi_o     = 4'b0000;
        core_hold_o    = 1'b0;
        prg_gnt_o      = 1'b0;
        prg_cipo_o     = 1'b0;
        if (!rst_i) begin
            core_hold_o = (state_q != ST_CORE);
            case (state_q)
                ST_CORE, ST_WAIT_IDLE: begin
                    qspi_sck_o     = core_sck_i;
                    qspi_cs_rom_no = core_cs_rom_ni;
                    qspi_cs_ram_no = core_cs_ram_ni;
                    qspi_sdo_o     = core_sdo_i;
                    qspi_sdoen_o   = core_sdoen_i;
                    core_sdi_o     = qspi_sdi_i;
                end
                ST_PRG: begin
                    qspi_sck_o     = prg_sck_i;
                    qspi_cs_rom_no = prg_cs_ni;
                    qspi_sdo_o     = {3'b000, prg_copi_i};
                    qspi_sdoen_o   = 4'b0001;
                    prg_cipo_o     = qspi_sdi_i[1];
                    prg_gnt_o      = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign conflict_o = conflict_q && !rst_i;

endmodule

// File: tb/tb_qspi_bus_arbiter.sv
// Directed self-checking bench for qspi_bus_arbiter (GUARD_CYCLES=4, PRG_TIMEOUT=16).
module tb_qspi_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       core_sck, core_cs_rom_n, core_cs_ram_n;
    logic [3:0] core_sdo, core_sdoen, core_sdi;
    logic       core_hold;
    logic       prg_req, prg_gnt, prg_sck, prg_cs_n, prg_copi, prg_cipo;
    logic       q_sck, q_cs_rom_n, q_cs_ram_n;
    logic [3:0] q_sdo, q_sdoen, q_sdi;
    logic       conflict;

    int n_chk  = 0;
    int n_fail = 0;

    qspi_bus_arbiter #(.GUARD_CYCLES(4), .PRG_TIMEOUT(16)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .core_sck_i     (core_sck),
        .core_cs_rom_ni (core_cs_rom_n),
        .core_cs_ram_ni (core_cs_ram_n),
        .core_sdo_i     (core_sdo),
        .core_sdoen_i   (core_sdoen),
        .core_sdi_o     (core_sdi),
        .core_hold_o    (core_hold),
        .prg_req_i      (prg_req),
        .prg_gnt_o      (prg_gnt),
        .prg_sck_i      (prg_sck),
        .prg_cs_ni      (prg_cs_n),
        .prg_copi_i     (prg_copi),
        .prg_cipo_o     (prg_cipo),
        .qspi_sck_o     (q_sck),
        .qspi_cs_rom_no (q_cs_rom_n),
        .qspi_cs_ram_no (q_cs_ram_n),
        .qspi_sdo_o     (q_sdo),
        .qspi_sdoen_o   (q_sdoen),
        .qspi_sdi_i     (q_sdi),
        .conflict_o     (conflict)
    );

    always #5 clk = ~clk;

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        core_sck = 1'b1; core_cs_rom_n = 1'b0; core_cs_ram_n = 1'b0;
        core_sdo = 4'hF; core_sdoen = 4'hF; q_sdi = 4'hF;
        prg_req = 1'b1; prg_sck = 1'b1; prg_cs_n = 1'b0; prg_copi = 1'b1;
        tick(); tick(); #1;
        n_chk++;
        if ({q_sck, q_cs_rom_n, q_cs_ram_n, q_sdo, q_sdoen} !== {1'b0, 1'b1, 1'b1, 4'h0, 4'h0}) begin
            n_fail++;
            $display("FAIL reset_pins: got sck=%b rom=%b ram=%b sdo=%h en=%h, need 0 1 1 0 0",
                     q_sck, q_cs_rom_n, q_cs_ram_n, q_sdo, q_sdoen);
        end
        n_chk++;
        if ({core_sdi, core_hold, prg_gnt, prg_cipo, conflict} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outs: got sdi=%h hold=%b gnt=%b cipo=%b conf=%b, need all 0",
                     core_sdi, core_hold, prg_gnt, prg_cipo, conflict);
        end
        prg_req = 1'b0; prg_sck = 1'b0; prg_cs_n = 1'b1; prg_copi = 1'b0;
        rst = 1'b0;
        tick(); #1;
        n_chk++;
        if ({q_sck, q_cs_rom_n, q_cs_ram_n, q_sdo, q_sdoen, core_sdi, core_hold}
            !== {1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 4'hF, 1'b0}) begin
            n_fail++;
            $display("FAIL core_route: got sck=%b rom=%b ram=%b sdo=%h en=%h sdi=%h hold=%b, need 1 0 0 f f f 0",
                     q_sck, q_cs_rom_n, q_cs_ram_n, q_sdo, q_sdoen, core_sdi, core_hold);
        end
        core_sck = 1'b0; core_cs_rom_n = 1'b1; core_cs_ram_n = 1'b1;
        core_sdo = 4'h0; core_sdoen = 4'h0; q_sdi = 4'h0;
    endtask

    task automatic test_wait_abort();
        tick();
        core_cs_rom_n = 1'b0; prg_req = 1'b1;
        tick(); #1;
        n_chk++;
        if (core_hold !== 1'b1 || q_cs_rom_n !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_idle: got hold=%b rom=%b, need 1 0", core_hold, q_cs_rom_n);
        end
        prg_req = 1'b0;
        tick(); #1;
        n_chk++;
        if (core_hold !== 1'b0 || prg_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_abort: got hold=%b gnt=%b, need 0 0", core_hold, prg_gnt);
        end
        core_cs_rom_n = 1'b1;
    endtask

    task automatic test_handover();
        int rise = -1;
        tick();
        core_cs_rom_n = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            tick();
            if (c == 5)  prg_req = 1'b1;
            if (c == 40) core_cs_rom_n = 1'b1;
            core_sck = c[0];
            #1;
            if (prg_gnt && rise < 0) rise = c;
            if (c == 20) begin
                n_chk++;
                if (q_cs_rom_n !== 1'b0 || q_sck !== core_sck || core_hold !== 1'b1) begin
                    n_fail++;
                    $display("FAIL inflight_route: got rom=%b sck=%b hold=%b, need 0 %b 1",
                             q_cs_rom_n, q_sck, core_hold, core_sck);
                end
            end
            if (c == 43) begin
                n_chk++;
                if (q_sck !== 1'b0 || q_cs_rom_n !== 1'b1 || prg_gnt !== 1'b0) begin
                    n_fail++;
                    $display("FAIL guard_in_idle: got sck=%b rom=%b gnt=%b, need 0 1 0",
                             q_sck, q_cs_rom_n, prg_gnt);
                end
            end
        end
        n_chk++;
        if (rise !== 45) begin
            n_fail++;
            $display("FAIL grant_latency: got cycle %0d, need 45", rise);
        end
        core_sck = 1'b0;
    endtask

    task automatic test_prg_data();
        logic b;
        prg_cs_n = 1'b0; q_sdi = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            tick();
            b = i[0];
            prg_copi = b; prg_sck = ~b;
            #1;
            n_chk++;
            if (q_sdo !== {3'b000, b} || q_sdoen !== 4'b0001 || prg_cipo !== 1'b1 ||
                core_sdi !== 4'h0 || q_sck !== ~b || q_cs_rom_n !== 1'b0 ||
                q_cs_ram_n !== 1'b1 || prg_gnt !== 1'b1) begin
                n_fail++;
                $display("FAIL prg_data[%0d]: got sdo=%h en=%h cipo=%b sdi=%h sck=%b rom=%b ram=%b gnt=%b, need %h 1 1 0 %b 0 1 1",
                         i, q_sdo, q_sdoen, prg_cipo, core_sdi, q_sck, q_cs_rom_n, q_cs_ram_n,
                         prg_gnt, {3'b000, b}, ~b);
            end
        end
        prg_sck = 1'b0; prg_copi = 1'b0;
    endtask

    task automatic test_conflict();
        tick();
        core_cs_ram_n = 1'b0;
        #1;
        n_chk++;
        if (q_cs_ram_n !== 1'b1 || conflict !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_pulse: got ram=%b conf=%b, need 1 0", q_cs_ram_n, conflict);
        end
        tick();
        core_cs_ram_n = 1'b1;
        #1;
        n_chk++;
        if (conflict !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict_set: got %b, need 1", conflict);
        end
        tick(); tick(); tick(); #1;
        n_chk++;
        if (conflict !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict_sticky: got %b, need 1", conflict);
        end
    endtask

    task automatic test_deferred_release();
        tick();
        prg_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            n_chk++;
            if (prg_gnt !== 1'b1) begin
                n_fail++;
                $display("FAIL defer_hold[%0d]: got gnt=%b, need 1", i, prg_gnt);
            end
        end
        tick();
        prg_cs_n = 1'b1; core_sck = 1'b1;
        #1;
        n_chk++;
        if (prg_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL defer_last: got gnt=%b, need 1", prg_gnt);
        end
        for (int g = 1; g <= 4; g++) begin
            tick(); #1;
            n_chk++;
            if (prg_gnt !== 1'b0 || core_hold !== 1'b1 || q_sck !== 1'b0 || q_cs_rom_n !== 1'b1) begin
                n_fail++;
                $display("FAIL guard_out[%0d]: got gnt=%b hold=%b sck=%b rom=%b, need 0 1 0 1",
                         g, prg_gnt, core_hold, q_sck, q_cs_rom_n);
            end
        end
        tick(); #1;
        n_chk++;
        if (core_hold !== 1'b0 || q_sck !== 1'b1) begin
            n_fail++;
            $display("FAIL back_to_core: got hold=%b sck=%b, need 0 1", core_hold, q_sck);
        end
        core_sck = 1'b0;
    endtask

    task automatic test_reset_mid_prg();
        bit got = 1'b0;
        tick();
        prg_req = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            tick(); #1;
            got = prg_gnt;
        end
        n_chk++;
        if (!got) begin
            n_fail++;
            $display("FAIL regrant: got no grant in 20 cycles, need grant");
        end
        tick();
        rst = 1'b1; prg_cs_n = 1'b0;
        #1;
        n_chk++;
        if (q_cs_rom_n !== 1'b1 || prg_gnt !== 1'b0 || conflict !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_force: got rom=%b gnt=%b conf=%b, need 1 0 0", q_cs_rom_n, prg_gnt, conflict);
        end
        tick();
        rst = 1'b0; core_sdo = 4'hA;
        #1;
        n_chk++;
        if (core_hold !== 1'b0 || prg_gnt !== 1'b0 || conflict !== 1'b0 ||
            q_sdo !== 4'hA || q_cs_rom_n !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_to_core: got hold=%b gnt=%b conf=%b sdo=%h rom=%b, need 0 0 0 a 1",
                     core_hold, prg_gnt, conflict, q_sdo, q_cs_rom_n);
        end
        prg_req = 1'b0; prg_cs_n = 1'b1; core_sdo = 4'h0;
        tick(); tick();
    endtask

`ifdef QSPI_ARB_PRG_TIMEOUT_EN
    task automatic test_timeout();
        bit got = 1'b0;
        int held = 0;
        tick();
        prg_req = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            tick(); #1;
            got = prg_gnt;
        end
        if (got) held = 1;
        for (int i = 0; i < 40 && prg_gnt; i++) begin
            tick(); #1;
            if (prg_gnt) held++;
        end
        n_chk++;
        if (held !== 16) begin
            n_fail++;
            $display("FAIL timeout_len: got %0d grant cycles, need 16", held);
        end
        for (int i = 0; i < 15; i++) tick();
        #1;
        n_chk++;
        if (prg_gnt !== 1'b0 || core_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL no_regrant: got gnt=%b hold=%b, need 0 0", prg_gnt, core_hold);
        end
        prg_req = 1'b0;
        tick();
        prg_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick(); #1;
            got = prg_gnt;
        end
        n_chk++;
        if (!got) begin
            n_fail++;
            $display("FAIL rearm_grant: got no grant after toggle, need grant");
        end
        prg_req = 1'b0;
        for (int i = 0; i < 8; i++) tick();
    endtask
`endif

    initial begin
        test_reset();
        test_wait_abort();
        test_handover();
        test_prg_data();
        test_conflict();
        test_deferred_release();
        test_reset_mid_prg();
`ifdef QSPI_ARB_PRG_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/qspi_bus_arbiter.md
QSPI_BUS_ARBITER -- requirements
Module: qspi_bus_arbiter

Interface
REQ-001 SHALL have parameter GUARD_CYCLES, default 4: bus-idle cycles before and after every ownership change (range 1..255).
REQ-002 SHALL have parameter PRG_TIMEOUT, default 1024: programmer-inactivity cycles before reclaim (range 2..65535, used only when the timeout feature is compiled in).
REQ-003 SHALL have ports, in this order:
- clk_i  in  1  system clock; the only clock.
- rst_i  in  1  reset, synchronous, active-high.
- core_sck_i  in  1  core QSPI clock.
- core_cs_rom_ni  in  1  core ROM chip select, active-low.
- core_cs_ram_ni  in  1  core RAM chip select, active-low.
- core_sdo_i  in  4  core data out.
- core_sdoen_i  in  4  core output enables.
- core_sdi_o  out  4  data returned to the core.
- core_hold_o  out  1  core SHALL NOT start a new transaction while high.
- prg_req_i  in  1  programmer requests the bus (level).
- prg_gnt_o  out  1  programmer owns the bus.
- prg_sck_i  in  1  programmer SPI clock.
- prg_cs_ni  in  1  programmer chip select (ROM only), active-low.
- prg_copi_i  in  1  programmer data out.
- prg_cipo_o  out  1  programmer data in.
- qspi_sck_o  out  1  pin-side QSPI clock.
- qspi_cs_rom_no  out  1  pin-side ROM select, active-low.
- qspi_cs_ram_no  out  1  pin-side RAM select, active-low.
- qspi_sdo_o  out  4  pin-side data out.
- qspi_sdoen_o  out  4  pin-side output enables.
- qspi_sdi_i  in  4  pin-side data in.
- conflict_o  out  1  sticky flag: core selected a device while not owner.

Function
REQ-004 SHALL implement states CORE, WAIT_IDLE, GUARD_IN, PRG, GUARD_OUT.
REQ-005 CORE SHALL route core signals to the pins combinationally, set core_sdi_o=qspi_sdi_i, core_hold_o=0, prg_gnt_o=0 and prg_cipo_o=0.
REQ-006 CORE SHALL go to WAIT_IDLE on prg_req_i=1; core_hold_o SHALL be 1 in every state except CORE.
REQ-007 WAIT_IDLE SHALL keep routing the core and go to GUARD_IN on the first cycle with both core chip selects high.
REQ-008 WAIT_IDLE SHALL return to CORE if prg_req_i drops first.
REQ-009 The bus SHALL be forced idle in GUARD_IN and GUARD_OUT: sck=0, both chip selects=1, sdo=0, sdoen=0.
REQ-010 Each guard state SHALL last exactly GUARD_CYCLES cycles; GUARD_IN then goes to PRG, GUARD_OUT then goes to CORE.
REQ-011 PRG SHALL drive qspi_sck_o=prg_sck_i, qspi_cs_rom_no=prg_cs_ni, qspi_cs_ram_no=1, qspi_sdo_o={3'b0,prg_copi_i}, qspi_sdoen_o=4'b0001, prg_cipo_o=qspi_sdi_i[1], prg_gnt_o=1, core_sdi_o=0.
REQ-012 PRG SHALL go to GUARD_OUT when prg_req_i=0 and prg_cs_ni=1; a request drop while prg_cs_ni=0 SHALL be deferred until prg_cs_ni rises.
REQ-013 conflict_o SHALL be set when either core chip select is low in GUARD_IN, PRG or GUARD_OUT, and SHALL be cleared only by reset.
REQ-014 The pin multiplexer SHALL be combinational from the registered state (zero added latency).

Reset
REQ-015 While rst_i=1: state=CORE, guard counter=0, conflict_o=0.
REQ-016 While rst_i=1 the pins SHALL be forced idle regardless of inputs; all other outputs SHALL be 0.
REQ-017 Reset asserted in any state SHALL return the block to CORE on the next clock edge with no guard period.

Configuration
REQ-018 With macro QSPI_ARB_PRG_TIMEOUT_EN defined, PRG SHALL count consecutive cycles with prg_cs_ni=1 and prg_sck_i=0 (reset on any activity).
REQ-019 With QSPI_ARB_PRG_TIMEOUT_EN defined, PRG SHALL go to GUARD_OUT after PRG_TIMEOUT such cycles even if prg_req_i=1.
REQ-020 With QSPI_ARB_PRG_TIMEOUT_EN defined, after a timeout a new grant SHALL require prg_req_i to fall and rise again.
REQ-021 Without QSPI_ARB_PRG_TIMEOUT_EN, the timeout counter and re-arm logic SHALL be absent and PRG SHALL leave only per REQ-012.

Structure
REQ-022 Package qspi_arb_pkg SHALL hold the state enum and bus-idle constants (IDLE_SCK=0, IDLE_CS_N=1, IDLE_SDOEN=4'b0000).
REQ-023 A single sub-module qspi_arb_timer (loadable down-counter with a done flag) SHALL serve the guard periods and the timeout.

Verification
REQ-024 Core ROM read in flight (cs_rom low 40 cycles), prg_req_i=1 at cycle 5 -> prg_gnt_o rises exactly 40+GUARD_CYCLES+1 cycles after cs_rom went low; pins stay core-driven until cs_rom rises.
REQ-025 PRG with prg_copi_i toggling and qspi_sdi_i=4'b0010 -> qspi_sdo_o=000x, sdoen=0001, prg_cipo_o=1, core_sdi_o=0.
REQ-026 prg_req_i drops while prg_cs_ni=0 -> grant holds until prg_cs_ni=1, then 4 idle cycles, then core routing with core_hold_o=0.
REQ-027 core_cs_ram_ni=0 pulsed during PRG -> conflict_o=1 and stays 1; qspi_cs_ram_no stays 1.
REQ-028 rst_i=1 for 1 cycle mid-PRG -> next cycle state CORE, pins core-routed, conflict_o=0.
REQ-029 With QSPI_ARB_PRG_TIMEOUT_EN and PRG_TIMEOUT=16, programmer idle with prg_req_i held at 1 -> GUARD_OUT after 16 cycles; no re-grant until prg_req_i toggles.
